// File: rtl/io_pkg.sv
// Shared geometry constants and FSM state type for the io_control sequencer.
package io_pkg;

    localparam int unsigned DRAW_W       = 11;
    localparam int unsigned DRAW_H       = 15;
    localparam int unsigned DRAW_PIXELS  = 165;

    localparam int unsigned ERASE_W      = 141;
    localparam int unsigned ERASE_H      = 197;
    localparam int unsigned ERASE_PIXELS = 27777;
    localparam int unsigned ERASE_X0     = 89;
    localparam int unsigned ERASE_Y0     = 33;

    localparam int unsigned CNT_W        = 15;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDraw,
        StErase,
        StDone
    } io_state_t;

endpackage

// File: rtl/io_req_slot.sv
// Single-entry request holding slot with a one-cycle acknowledge pulse.
module io_req_slot #(
    parameter int unsigned PayloadW = 8,
    localparam int unsigned StoreW  = (PayloadW == 0) ? 1 : PayloadW
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_i,
    input  logic [StoreW-1:0] data_i,
    input  logic              take_i,
    output logic              full_o,
    output logic              ack_o,
    output logic [StoreW-1:0] data_o
);

    logic full_q, full_d;
    logic ack_q, ack_d;
    logic accept;

    // The ack term stops a still-high request from being taken twice.
    always_comb begin
        accept = req_i & ~full_q & ~ack_q;
        ack_d  = accept;
        full_d = full_q;
        if (accept) begin
            full_d = 1'b1;
        end else if (take_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            full_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            ack_q  <= ack_d;
        end
    end

    assign full_o = full_q;
    assign ack_o  = ack_q;

    if (PayloadW == 0) begin : g_no_payload
        logic unused_data;
        assign unused_data = ^data_i;
        assign data_o      = '0;
    end else begin : g_payload
        logic [StoreW-1:0] data_q, data_d;

        always_comb begin
            data_d = accept ? data_i : data_q;
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign data_o = data_q;
    end

endmodule

// File: rtl/io_control.sv
// Draw/clear sequencer for io_datapath: arbitrates requests (clear first),
// counts pixels and drives the datapath controls plus the VGA plot strobe.
module io_control
    import io_pkg::*;
#(
    parameter int unsigned         COLOUR_W     = 3,
    parameter logic [COLOUR_W-1:0] ERASE_COLOUR = '0
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                draw_req,
    input  logic [7:0]          draw_x,
    input  logic [7:0]          draw_y,
    input  logic [COLOUR_W-1:0] draw_colour,
    output logic                draw_ack,
    input  logic                clear_req,
    output logic                clear_ack,
    output logic                dp_count_reset,
    output logic                dp_draw,
    output logic                dp_erase,
    output logic [7:0]          dp_x_in,
    output logic [7:0]          dp_y_in,
    output logic                plot,
    output logic [COLOUR_W-1:0] colour,
    output logic                busy,
    output logic                done
);

    localparam int unsigned DrawPayloadW = 16 + COLOUR_W;

    io_state_t             state_q, state_d;
    logic                  op_erase_q, op_erase_d;
    logic [7:0]            x_q, x_d, y_q, y_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                    draw_full, clear_full, take_draw, take_clear;
    logic [DrawPayloadW-1:0] draw_slot_data;
    logic                    unused_clear_data;

    io_req_slot #(
        .PayloadW (DrawPayloadW)
    ) u_draw_slot (
        .clock  (clock),
        .resetn (resetn),
        .req_i  (draw_req),
        .data_i ({draw_x, draw_y, draw_colour}),
        .take_i (take_draw),
        .full_o (draw_full),
        .ack_o  (draw_ack),
        .data_o (draw_slot_data)
    );

    io_req_slot #(
        .PayloadW (0)
    ) u_clear_slot (
        .clock  (clock),
        .resetn (resetn),
        .req_i  (clear_req),
        .data_i (1'b0),
        .take_i (take_clear),
        .full_o (clear_full),
        .ack_o  (clear_ack),
        .data_o (unused_clear_data)
    );

    assign take_clear = (state_q == StIdle) & clear_full;
    assign take_draw  = (state_q == StIdle) & draw_full & ~clear_full;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            op_erase_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_erase_q <= op_erase_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_erase_d = op_erase_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (take_clear) begin
                    state_d    = StLoad;
                    op_erase_d = 1'b1;
                end else if (take_draw) begin
                    state_d    = StLoad;
                    op_erase_d = 1'b0;
                end
            end
            StLoad: begin
                // Slot payload is still intact here: a new accept lands on this same edge.
                if (op_erase_q) begin
                    state_d = StErase;
                    x_d     = 8'(ERASE_X0);
                    y_d     = 8'(ERASE_Y0);
                    cnt_d   = CNT_W'(ERASE_PIXELS - 1);
                end else begin
                    state_d  = StDraw;
                    x_d      = draw_slot_data[DrawPayloadW-1 -: 8];
                    y_d      = draw_slot_data[COLOUR_W +: 8];
                    colour_d = draw_slot_data[COLOUR_W-1:0];
                    cnt_d    = CNT_W'(DRAW_PIXELS - 1);
                end
            end
            StDraw, StErase: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dp_count_reset = 1'b0;
        dp_draw        = 1'b0;
        dp_erase       = 1'b0;
        plot           = 1'b0;
        colour         = '0;
        done           = 1'b0;
        unique case (state_q)
            StDraw: begin
                dp_count_reset = 1'b1;
                dp_draw        = 1'b1;
                plot           = 1'b1;
                colour         = colour_q;
            end
            StErase: begin
                dp_count_reset = 1'b1;
                dp_erase       = 1'b1;
                plot           = 1'b1;
                colour         = ERASE_COLOUR;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (state_q != StIdle) | draw_full | clear_full;
    assign dp_x_in = x_q;
    assign dp_y_in = y_q;

endmodule

// File: tb/tb_io_control.sv
// Self-checking bench for io_control with a behavioural datapath and pixel-stream model.
module tb_io_control;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       draw_req = 1'b0, clear_req = 1'b0;
    logic [7:0] draw_x = '0, draw_y = '0;
    logic [2:0] draw_colour = '0;
    logic       draw_ack, clear_ack, dp_count_reset, dp_draw, dp_erase;
    logic [7:0] dp_x_in, dp_y_in;
    logic       plot, busy, done;
    logic [2:0] colour;

    io_control #(
        .COLOUR_W     (3),
        .ERASE_COLOUR (3'd0)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .draw_req       (draw_req),
        .draw_x         (draw_x),
        .draw_y         (draw_y),
        .draw_colour    (draw_colour),
        .draw_ack       (draw_ack),
        .clear_req      (clear_req),
        .clear_ack      (clear_ack),
        .dp_count_reset (dp_count_reset),
        .dp_draw        (dp_draw),
        .dp_erase       (dp_erase),
        .dp_x_in        (dp_x_in),
        .dp_y_in        (dp_y_in),
        .plot           (plot),
        .colour         (colour),
        .busy           (busy),
        .done           (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } pix_t;

    typedef struct {
        int x;
        int y;
        int c;
        int fx;
        int fy;
        int lx;
        int ly;
    } vec_t;

    pix_t got_q[$];
    pix_t exp_q[$];
    int   done_cyc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   idx = 0;
    int   done_cnt = 0, dack_cnt = 0, cack_cnt = 0, both_hi = 0, plot_bad = 0;

    function automatic pix_t mk_pix(input int x, input int y, input int c, input int t);
        pix_t p;
        p.x   = x % 256;
        p.y   = y % 256;
        p.c   = c;
        p.cyc = t;
        return p;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Datapath stand-in: linear pixel index, cleared while count_reset is low.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) idx <= 0;
        else if (!dp_count_reset) idx <= 0;
        else if (dp_draw | dp_erase) idx <= idx + 1;
    end

    always @(negedge clock) begin
        if (plot) begin
            got_q.push_back(mk_pix(int'(dp_x_in) + idx % (dp_erase ? 141 : 11),
                                   int'(dp_y_in) + idx / (dp_erase ? 141 : 11),
                                   int'(colour), cyc));
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc_q.push_back(cyc);
        end
        if (draw_ack) dack_cnt <= dack_cnt + 1;
        if (clear_ack) cack_cnt <= cack_cnt + 1;
        if (dp_draw & dp_erase) both_hi <= both_hi + 1;
        if (plot & ~(dp_draw | dp_erase)) plot_bad <= plot_bad + 1;
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic flush();
        got_q.delete();
        exp_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic exp_block(input int x0, input int y0, input int w, input int h, input int c);
        for (int k = 0; k < w * h; k++) exp_q.push_back(mk_pix(x0 + k % w, y0 + k / w, c, 0));
    endtask

    task automatic cmp_stream(input string name);
        int mism = 0;
        int n;
        chk({name, " plot count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y || got_q[i].c != exp_q[i].c)
                mism++;
        end
        chk({name, " pixel mismatches"}, mism, 0);
    endtask

    task automatic req_draw(input int x, input int y, input int c, output int ack_cyc);
        draw_x      = 8'(x);
        draw_y      = 8'(y);
        draw_colour = 3'(c);
        draw_req    = 1'b1;
        ack_cyc     = -1;
        for (int i = 0; i < 40000 && ack_cyc < 0; i++) begin
            step();
            if (draw_ack) ack_cyc = cyc;
        end
        draw_req = 1'b0;
        chk("draw_ack seen", int'(ack_cyc >= 0), 1);
    endtask

    task automatic wait_done(input int target, input int bound, input string name);
        int n = 0;
        while (done_cnt < target && n < bound) begin
            step();
            n++;
        end
        chk(name, int'(done_cnt >= target), 1);
    endtask

    task automatic zero_outputs(input string name);
        chk({name, " outputs"}, int'({plot, dp_draw, dp_erase, dp_count_reset, draw_ack,
                                     clear_ack, busy, done, dp_x_in, dp_y_in, colour}), 0);
    endtask

    task automatic run_draw(input int x, input int y, input int c);
        int ack, base, dbase;
        flush();
        base  = done_cnt;
        dbase = dack_cnt;
        req_draw(x, y, c, ack);
        wait_done(base + 1, 400, "draw done");
        step();
        step();
        chk("draw ack pulses", dack_cnt - dbase, 1);
        chk("done pulses", done_cnt - base, 1);
        chk("first plot latency", (got_q.size() > 0) ? got_q[0].cyc - ack : -1, 2);
        chk("op length", (done_cyc_q.size() > 0) ? done_cyc_q[0] - ack : -1, 167);
        chk("busy after draw", busy, 0);
        chk("dp counter cleared", idx, 0);
        chk("dp_x_in holds origin", dp_x_in, x);
        chk("dp_y_in holds origin", dp_y_in, y);
        exp_block(x, y, 11, 15, c);
        cmp_stream("draw");
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int   da, ca, n, base, a_ack, b_ack, c_ack, n0;

        tbl[0] = '{x: 20,  y: 40,  c: 5, fx: 20,  fy: 40,  lx: 30,  ly: 54};
        tbl[1] = '{x: 250, y: 250, c: 3, fx: 250, fy: 250, lx: 4,   ly: 8};
        tbl[2] = '{x: 0,   y: 0,   c: 7, fx: 0,   fy: 0,   lx: 10,  ly: 14};
        tbl[3] = '{x: 245, y: 241, c: 1, fx: 245, fy: 241, lx: 255, ly: 255};
        tbl[4] = '{x: 255, y: 0,   c: 2, fx: 255, fy: 0,   lx: 9,   ly: 14};

        step();
        step();
        zero_outputs("in reset");
        resetn = 1'b1;
        step();
        zero_outputs("after reset");

        for (int i = 0; i < 5; i++) begin
            run_draw(tbl[i].x, tbl[i].y, tbl[i].c);
            if (got_q.size() > 0) begin
                chk("table first x", got_q[0].x, tbl[i].fx);
                chk("table first y", got_q[0].y, tbl[i].fy);
                chk("table last x", got_q[got_q.size() - 1].x, tbl[i].lx);
                chk("table last y", got_q[got_q.size() - 1].y, tbl[i].ly);
                chk("table colour", got_q[0].c, tbl[i].c);
            end
        end

        for (int i = 0; i < 6; i++) begin
            run_draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 7)));
        end

        // Single clear.
        flush();
        base = done_cnt;
        clear_req = 1'b1;
        ca = -1;
        for (int i = 0; i < 20 && ca < 0; i++) begin
            step();
            if (clear_ack) ca = cyc;
        end
        clear_req = 1'b0;
        chk("clear_ack seen", int'(ca >= 0), 1);
        wait_done(base + 1, 30000, "clear done");
        step();
        step();
        chk("clear done pulses", done_cnt - base, 1);
        if (got_q.size() > 0) begin
            chk("clear first x", got_q[0].x, 89);
            chk("clear first y", got_q[0].y, 33);
            chk("clear last x", got_q[got_q.size() - 1].x, 229);
            chk("clear last y", got_q[got_q.size() - 1].y, 229);
        end
        chk("clear dp counter cleared", idx, 0);
        chk("busy after clear", busy, 0);
        exp_block(89, 33, 141, 197, 0);
        cmp_stream("clear");

        // Draw and clear raised together: clear runs first.
        flush();
        base = done_cnt;
        draw_x = 8'd40;
        draw_y = 8'd60;
        draw_colour = 3'd6;
        draw_req = 1'b1;
        clear_req = 1'b1;
        da = -1;
        ca = -1;
        for (int i = 0; i < 20 && (da < 0 || ca < 0); i++) begin
            step();
            if (draw_ack) begin
                da = cyc;
                draw_req = 1'b0;
            end
            if (clear_ack) begin
                ca = cyc;
                clear_req = 1'b0;
            end
        end
        draw_req = 1'b0;
        clear_req = 1'b0;
        chk("both acked", int'(da >= 0 && ca >= 0), 1);
        chk("acks same cycle", da - ca, 0);
        wait_done(base + 2, 30000, "both done");
        step();
        chk("two done pulses", done_cnt - base, 2);
        exp_block(89, 33, 141, 197, 0);
        exp_block(40, 60, 11, 15, 6);
        cmp_stream("clear then draw");

        // Third draw queued behind a pending one waits for the slot to empty.
        flush();
        base = done_cnt;
        req_draw(10, 20, 1, a_ack);
        n = 0;
        while (got_q.size() < 50 && n < 300) begin
            step();
            n++;
        end
        req_draw(30, 40, 2, b_ack);
        req_draw(60, 70, 4, c_ack);
        wait_done(base + 3, 1000, "queued done");
        step();
        chk("second ack during first op",
            int'(done_cyc_q.size() > 0 && b_ack < done_cyc_q[0]), 1);
        chk("third ack after slot frees", (done_cyc_q.size() > 0) ? c_ack - done_cyc_q[0] : -1, 3);
        exp_block(10, 20, 11, 15, 1);
        exp_block(30, 40, 11, 15, 2);
        exp_block(60, 70, 11, 15, 4);
        cmp_stream("queued draws");

        // Asynchronous reset in the middle of a draw.
        flush();
        req_draw(100, 100, 6, a_ack);
        n = 0;
        while (got_q.size() < 80 && n < 300) begin
            step();
            n++;
        end
        #2;
        resetn = 1'b0;
        #1;
        zero_outputs("mid-op reset");
        step();
        step();
        resetn = 1'b1;
        base = done_cnt;
        n0 = got_q.size();
        for (int i = 0; i < 12; i++) step();
        chk("no plots after reset", got_q.size(), n0);
        chk("no done after reset", done_cnt - base, 0);
        chk("idle after reset", busy, 0);
        run_draw(7, 9, 3);

        chk("draw/erase exclusive", both_hi, 0);
        chk("plot only while drawing", plot_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
